// File: rtl/rsa_pkg.sv
// Shared types and constants for the 8-bit RSA modular exponentiator.
package rsa_pkg;

    localparam int RSA_W    = 8;
    localparam int STEPS    = 8;
    localparam int BUSY_LEN = 136;

    typedef enum logic [2:0] {
        IDLE,
        RED,
        MUL,
        SQR,
        DONE
    } state_t;

    // One conditional subtract; callers guarantee x < 2n.
    function automatic logic [RSA_W-1:0] mod_sub(
        input logic [RSA_W:0]   x,
        input logic [RSA_W-1:0] n
    );
        logic [RSA_W:0] d;
        d = x - {1'b0, n};
        return (x >= {1'b0, n}) ? d[RSA_W-1:0] : x[RSA_W-1:0];
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Iterative a*b mod n, one multiplier bit per cycle, MSB first.
module rsa_modmul
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RSA_W-1:0] a,
    input  logic [RSA_W-1:0] b,
    input  logic [RSA_W-1:0] n,
    output logic             done,
    output logic [RSA_W-1:0] res
);

    logic [2:0]       cnt;
    logic [RSA_W-1:0] t;
    logic [RSA_W-1:0] t_in;
    logic [RSA_W-1:0] dbl;
    logic [RSA_W:0]   sum;

    // Doubling and adding are reduced separately so t < n holds with a < n.
    always_comb begin
        t_in = (cnt == 3'd0) ? '0 : t;
        dbl  = mod_sub({t_in, 1'b0}, n);
        sum  = {1'b0, dbl} + (b[~cnt] ? {1'b0, a} : '0);
        res  = mod_sub(sum, n);
        done = start && (cnt == 3'(STEPS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            t   <= '0;
        end else if (start) begin
            cnt <= cnt + 3'd1;
            t   <= res;
        end
    end

endmodule

// File: rtl/rsa_modexp.sv
// Constant-time right-to-left square-and-multiply over an 8-bit modulus.
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter logic CLK_EDGE = 1'b1
) (
    input  logic             exp_clk,
    input  logic             exp_rst,
    input  logic             exp_start,
    input  logic [RSA_W-1:0] exp_msg,
    input  logic [RSA_W-1:0] exp_key,
    input  logic [RSA_W-1:0] exp_mod,
    output logic [RSA_W-1:0] exp_res,
    output logic             exp_busy,
    output logic             exp_done,
    output logic             exp_err
);

    logic clk;
    assign clk = CLK_EDGE ? exp_clk : ~exp_clk;

    state_t           state;
    state_t           state_nx;
    logic [RSA_W-1:0] msg;
    logic [RSA_W-1:0] key;
    logic [RSA_W-1:0] mod;
    logic [RSA_W-1:0] base;
    logic [RSA_W-1:0] acc;
    logic [2:0]       bit_idx;
    logic             mm_start;
    logic             mm_done;
    logic [RSA_W-1:0] mm_a;
    logic [RSA_W-1:0] mm_b;
    logic [RSA_W-1:0] mm_res;
    logic             bad_mod;

    assign bad_mod = exp_mod < 8'd2;

    rsa_modmul u_mul (
        .clk   (clk),
        .rst   (exp_rst),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (mod),
        .done  (mm_done),
        .res   (mm_res)
    );

    always_ff @(posedge clk or posedge exp_rst) begin
        if (exp_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mm_start = 1'b0;
        mm_a     = acc;
        mm_b     = base;
        unique case (state)
            IDLE: begin
                if (exp_start) state_nx = bad_mod ? DONE : RED;
            end
            RED: begin
                mm_start = 1'b1;
                mm_a     = 8'd1;
                mm_b     = msg;
                if (mm_done) state_nx = MUL;
            end
            MUL: begin
                mm_start = 1'b1;
                if (mm_done) state_nx = SQR;
            end
            SQR: begin
                mm_start = 1'b1;
                mm_a     = base;
                if (mm_done) state_nx = (bit_idx == 3'd7) ? DONE : MUL;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // MUL always runs; only the commit depends on the key bit.
    always_ff @(posedge clk or posedge exp_rst) begin
        if (exp_rst) begin
            msg     <= '0;
            key     <= '0;
            mod     <= '0;
            base    <= '0;
            acc     <= '0;
            bit_idx <= '0;
            exp_res <= '0;
            exp_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (exp_start) begin
                        msg     <= exp_msg;
                        key     <= exp_key;
                        mod     <= exp_mod;
                        acc     <= 8'd1;
                        bit_idx <= '0;
                        exp_err <= bad_mod;
                        if (bad_mod) exp_res <= '0;
                    end
                end
                RED: begin
                    if (mm_done) base <= mm_res;
                end
                MUL: begin
                    if (mm_done && key[bit_idx]) acc <= mm_res;
                end
                SQR: begin
                    if (mm_done) begin
                        base    <= mm_res;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) exp_res <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign exp_busy = (state == RED) || (state == MUL) || (state == SQR);
    assign exp_done = (state == DONE);

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed bench for rsa_modexp: fixed vectors, abort/reset cases, n sweep.
module tb_rsa_modexp;

    logic       exp_clk;
    logic       exp_rst;
    logic       exp_start;
    logic [7:0] exp_msg;
    logic [7:0] exp_key;
    logic [7:0] exp_mod;
    logic [7:0] exp_res;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;

    int checks = 0;
    int errors = 0;

    rsa_modexp dut (
        .exp_clk   (exp_clk),
        .exp_rst   (exp_rst),
        .exp_start (exp_start),
        .exp_msg   (exp_msg),
        .exp_key   (exp_key),
        .exp_mod   (exp_mod),
        .exp_res   (exp_res),
        .exp_busy  (exp_busy),
        .exp_done  (exp_done),
        .exp_err   (exp_err)
    );

    initial exp_clk = 1'b0;
    always #5 exp_clk = ~exp_clk;

    task automatic tick;
        @(posedge exp_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_exp(input int m, input int e, input int n);
        int r;
        int b;
        if (n < 2) return 0;
        r = 1;
        b = m % n;
        for (int i = 0; i < 8; i++) begin
            if (((e >> i) & 1) == 1) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r;
    endfunction

    // Display decoder seen by exp_res: two hex digits, gfedcba active high.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [13:0] disp(input logic [7:0] v);
        return {seg7(v[7:4]), seg7(v[3:0])};
    endfunction

    task automatic run_op(input logic [7:0] m, input logic [7:0] e,
                          input logic [7:0] n, input int pulse_at,
                          output logic [7:0] res, output logic err,
                          output int cyc, output logic err0);
        exp_msg   = m;
        exp_key   = e;
        exp_mod   = n;
        exp_start = 1'b1;
        tick;
        exp_start = 1'b0;
        exp_msg   = 8'($urandom);
        exp_key   = 8'($urandom);
        exp_mod   = 8'($urandom);
        cyc  = 1;
        err0 = exp_err;
        while (!exp_done && cyc < 400) begin
            if (cyc == pulse_at) begin
                exp_start = 1'b1;
                exp_mod   = 8'd1;
            end
            tick;
            exp_start = 1'b0;
            cyc++;
        end
        res = exp_res;
        err = exp_err;
        tick;
    endtask

    initial begin
        logic [7:0] res;
        logic       err;
        logic       err0;
        int         cyc;
        int         busy_cnt;
        int         done_early;
        int         m;
        int         e;

        exp_rst   = 1'b1;
        exp_start = 1'b0;
        exp_msg   = '0;
        exp_key   = '0;
        exp_mod   = '0;
        repeat (2) tick;
        check("rst_res", exp_res, 0);
        check("rst_busy", exp_busy, 0);
        check("rst_done", exp_done, 0);
        check("rst_err", exp_err, 0);
        exp_rst = 1'b0;

        // 2^7 mod 143, started on the first edge after reset release
        exp_msg   = 8'd2;
        exp_key   = 8'd7;
        exp_mod   = 8'd143;
        exp_start = 1'b1;
        tick;
        exp_start  = 1'b0;
        exp_msg    = 8'd99;
        exp_key    = 8'd255;
        exp_mod    = 8'd0;
        busy_cnt   = 0;
        done_early = 0;
        for (int k = 1; k <= 136; k++) begin
            if (exp_busy) busy_cnt++;
            if (exp_done) done_early++;
            tick;
        end
        check("busy_len", busy_cnt, 136);
        check("done_early", done_early, 0);
        check("done_at_137", exp_done, 1);
        check("busy_at_137", exp_busy, 0);
        check("res_2_7", exp_res, 128);
        check("err_2_7", exp_err, 0);
        tick;
        check("done_pulse", exp_done, 0);
        check("res_hold", exp_res, 128);

        run_op(8'd128, 8'd103, 8'd143, 0, res, err, cyc, err0);
        check("res_128_103", res, 2);
        check("cyc_128_103", cyc, 137);

        run_op(8'd200, 8'd1, 8'd143, 0, res, err, cyc, err0);
        check("res_200_1", res, 57);
        run_op(8'd200, 8'd0, 8'd143, 0, res, err, cyc, err0);
        check("res_200_0", res, 1);

        run_op(8'd5, 8'd3, 8'd1, 0, res, err, cyc, err0);
        check("bad_err", err, 1);
        check("bad_res", res, 0);
        check("bad_cyc", cyc, 1);
        run_op(8'd9, 8'd5, 8'd0, 0, res, err, cyc, err0);
        check("bad0_err", err, 1);

        // err from the previous illegal op must clear on the new start
        run_op(8'd7, 8'd11, 8'd187, 50, res, err, cyc, err0);
        check("err_clr", err0, 0);
        check("ign_res", res, ref_exp(7, 11, 187));
        check("ign_err", err, 0);
        check("ign_cyc", cyc, 137);

        exp_msg   = 8'd3;
        exp_key   = 8'd200;
        exp_mod   = 8'd251;
        exp_start = 1'b1;
        tick;
        exp_start = 1'b0;
        repeat (69) tick;
        check("pre_rst_busy", exp_busy, 1);
        exp_rst = 1'b1;
        #1;
        check("mid_rst_res", exp_res, 0);
        check("mid_rst_busy", exp_busy, 0);
        check("mid_rst_done", exp_done, 0);
        check("mid_rst_err", exp_err, 0);
        tick;
        exp_rst = 1'b0;
        run_op(8'd3, 8'd200, 8'd251, 0, res, err, cyc, err0);
        check("post_rst_res", res, ref_exp(3, 200, 251));
        check("post_rst_cyc", cyc, 137);

        for (int n = 2; n <= 255; n++) begin
            m = int'($urandom_range(0, 255));
            e = int'($urandom_range(0, 255));
            run_op(8'(m), 8'(e), 8'(n), 0, res, err, cyc, err0);
            if (res !== 8'(ref_exp(m, e, n)))
                $display("sweep n=%0d m=%0d e=%0d", n, m, e);
            check("sweep_res", res, ref_exp(m, e, n));
            check("sweep_disp", disp(res), disp(8'(ref_exp(m, e, n))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
